prio_arb: RTL and testbench

Registered, parametrised request arbiter. It is the sequential successor of the combinational MSB-first priority encoder. It selects one of N requesters in either fixed-priority (MSB-first) or round-robin mode. The grant is presented through a valid/ready handshake and held stable until it is accepted, and a saturating count of accepted grants is kept. It sits between N request sources and a single shared downstream resource.

---
 rtl/prio_arb.sv | 126 ++++++++++++
 tb/tb_prio_arb.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/prio_arb.sv
// Registered fixed-priority / round-robin arbiter. 1-cycle req-to-grant latency, no bubble between back-to-back accepts.
// Backpressure: the grant is held stable while gnt_ready is low and is counted only when accepted.
module prio_arb #(
    parameter  int N  = 8,
    parameter  int CW = 16,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          mode,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_valid,
    input  logic          gnt_ready,
    output logic [CW-1:0] gnt_cnt
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_sel;
    logic          accept;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [N-1:0]  win_vec;
    logic          load;
    logic          clear;

    assign accept  = gnt_valid & gnt_ready;
    // On an accept the pointer moves to the accepted id in the same edge,
    // so re-arbitration must already use that value.
    assign ptr_sel = accept ? gnt_id : ptr;

    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    win_found = 1'b1;
                    win_idx   = IW'(i);
                end
            end
        end else begin
            // Walk the order back-to-front so the earliest position (ptr-1) is assigned last.
            for (int k = N - 1; k >= 0; k--) begin
                idx = (int'(ptr_sel) + N - 1 - k) % N;
                if (req[idx]) begin
                    win_found = 1'b1;
                    win_idx   = IW'(idx);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            win_vec[i] = win_found && (win_idx == IW'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt = GRANT;
                    load      = 1'b1;
                end
            end
            GRANT: begin
                if (accept) begin
                    if (win_found) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        clear     = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                clear     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            gnt_cnt   <= '0;
            ptr       <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                gnt       <= win_vec;
                gnt_id    <= win_idx;
                gnt_valid <= 1'b1;
            end else if (clear) begin
                gnt       <= '0;
                gnt_id    <= '0;
                gnt_valid <= 1'b0;
            end
            if (accept) begin
                ptr <= gnt_id;
                if (gnt_cnt != '1) begin
                    gnt_cnt <= gnt_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prio_arb.sv
// Directed bench for prio_arb: N=4 main instance, CW=2 instance for saturation, N=1 instance.
module tb_prio_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic        mode;
    logic        gnt_ready;

    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        gnt_valid;
    logic [15:0] gnt_cnt;

    logic [3:0]  gnt_s;
    logic [1:0]  gnt_id_s;
    logic        gnt_valid_s;
    logic [1:0]  gnt_cnt_s;

    logic [0:0]  gnt_1;
    logic [0:0]  gnt_id_1;
    logic        gnt_valid_1;
    logic [3:0]  gnt_cnt_1;

    int n_cmp;
    int n_fail;

    prio_arb #(.N(4), .CW(16)) u_dut (
        .clk(clk), .rst(rst), .req(req), .mode(mode),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid),
        .gnt_ready(gnt_ready), .gnt_cnt(gnt_cnt)
    );

    prio_arb #(.N(4), .CW(2)) u_sat (
        .clk(clk), .rst(rst), .req(req), .mode(mode),
        .gnt(gnt_s), .gnt_id(gnt_id_s), .gnt_valid(gnt_valid_s),
        .gnt_ready(gnt_ready), .gnt_cnt(gnt_cnt_s)
    );

    prio_arb #(.N(1), .CW(4)) u_one (
        .clk(clk), .rst(rst), .req(req[0:0]), .mode(mode),
        .gnt(gnt_1), .gnt_id(gnt_id_1), .gnt_valid(gnt_valid_1),
        .gnt_ready(gnt_ready), .gnt_cnt(gnt_cnt_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_id,
                             input logic e_vld, input logic [15:0] e_cnt);
        chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(e_id));
        chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(e_vld));
        chk({tag, ".gnt_cnt"}, 32'(gnt_cnt), 32'(e_cnt));
    endtask

    logic [3:0] rr_gnt [4];
    logic [1:0] rr_id  [4];

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rr_gnt = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
        rr_id  = '{2'd2, 2'd1, 2'd0, 2'd3};

        rst = 1'b1; req = 4'b0000; mode = 1'b0; gnt_ready = 1'b0;
        step(); step();
        check_dut("reset", 4'b0000, 2'd0, 1'b0, 16'd0);
        chk("reset.sat_cnt", 32'(gnt_cnt_s), 32'd0);
        chk("reset.n1_valid", 32'(gnt_valid_1), 32'd0);

        rst = 1'b0;
        step(); step();
        check_dut("idle_noreq", 4'b0000, 2'd0, 1'b0, 16'd0);
        chk("idle_noreq.sat_valid", 32'(gnt_valid_s), 32'd0);
        chk("idle_noreq.sat_cnt", 32'(gnt_cnt_s), 32'd0);

        // Fixed priority, req=1010 held, always ready
        mode = 1'b0; req = 4'b1010; gnt_ready = 1'b1;
        step();
        check_dut("fp_first", 4'b1000, 2'd3, 1'b1, 16'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_dut("fp_run", 4'b1000, 2'd3, 1'b1, 16'(k));
            chk("sat_cnt", 32'(gnt_cnt_s), (k > 3) ? 32'd3 : 32'(k));
            chk("fp_run.n1_valid", 32'(gnt_valid_1), 32'd0);
        end

        // Reset lands on an in-flight handshake
        rst = 1'b1;
        step();
        check_dut("rst_mid", 4'b0000, 2'd0, 1'b0, 16'd0);
        chk("rst_mid.sat_cnt", 32'(gnt_cnt_s), 32'd0);
        rst = 1'b0; mode = 1'b1; req = 4'b1001; gnt_ready = 1'b0;
        step();
        check_dut("rst_rel", 4'b1000, 2'd3, 1'b1, 16'd0);
        gnt_ready = 1'b1;
        step();
        check_dut("rst_ptr3", 4'b0001, 2'd0, 1'b1, 16'd1);

        // Round robin, all requesting, from reset
        rst = 1'b1; req = 4'b1111; gnt_ready = 1'b1; mode = 1'b1;
        step();
        rst = 1'b0;
        step();
        check_dut("rr0", 4'b1000, 2'd3, 1'b1, 16'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_dut("rr", rr_gnt[k], rr_id[k], 1'b1, 16'(k + 1));
        end

        // Hold under backpressure; sticky against req drop and mode change
        rst = 1'b1; req = 4'b0000; gnt_ready = 1'b0;
        step();
        rst = 1'b0; mode = 1'b1; req = 4'b0110;
        step();
        check_dut("hold1", 4'b0100, 2'd2, 1'b1, 16'd0);
        req = 4'b0010; mode = 1'b0;
        step();
        check_dut("hold2", 4'b0100, 2'd2, 1'b1, 16'd0);
        step();
        check_dut("hold3", 4'b0100, 2'd2, 1'b1, 16'd0);
        req = 4'b0110; mode = 1'b1; gnt_ready = 1'b1;
        step();
        check_dut("hold_acc", 4'b0010, 2'd1, 1'b1, 16'd1);

        // Drain to idle and single-cycle request
        req = 4'b0000;
        step();
        check_dut("drain_idle", 4'b0000, 2'd0, 1'b0, 16'd2);
        req = 4'b0001;
        step();
        check_dut("drain_g", 4'b0001, 2'd0, 1'b1, 16'd2);
        chk("drain_g.n1_gnt", 32'(gnt_1), 32'd1);
        chk("drain_g.n1_valid", 32'(gnt_valid_1), 32'd1);
        chk("drain_g.n1_id", 32'(gnt_id_1), 32'd0);
        req = 4'b0000;
        step();
        check_dut("drain_end", 4'b0000, 2'd0, 1'b0, 16'd3);
        chk("drain_end.n1_gnt", 32'(gnt_1), 32'd0);
        chk("drain_end.n1_cnt", 32'(gnt_cnt_1), 32'd1);
        step();
        check_dut("drain_stay", 4'b0000, 2'd0, 1'b0, 16'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
